// File: rtl/user_gpio_pkg.sv
// Shared constants and helpers for the user GPIO input path and its register block.
package user_gpio_pkg;

    localparam int          GPIO_WIDTH_DEF      = 32;
    localparam int          GPIO_SYNC_DEF       = 2;
    localparam int          GPIO_DEBOUNCE_DEF   = 16;
    localparam logic [31:0] GPIO_RESET_LVL_DEF  = 32'h0000_0000;

    // Byte offsets reserved in the AXI-Lite map for the edge-status and mask registers.
    localparam logic [7:0]  ADDR_GPIO_DATA   = 8'h00;
    localparam logic [7:0]  ADDR_GPIO_STICKY = 8'h08;
    localparam logic [7:0]  ADDR_GPIO_MASK   = 8'h0C;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/user_gpio_in_cond_bit.sv
// One GPIO bit: synchroniser chain, debounce counter, stable level and edge strobes.
module user_gpio_in_cond_bit
    import user_gpio_pkg::*;
#(
    parameter int   C_SYNC_STAGES     = GPIO_SYNC_DEF,
    parameter int   C_DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
    parameter logic C_RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic rise_next,
    output logic fall_next
);

    localparam int CNT_W = (clog2(C_DEBOUNCE_CYCLES) > 1) ? clog2(C_DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_DEBOUNCE_CYCLES - 1);

    logic [C_SYNC_STAGES-1:0] chain;
    logic                     sync;
    logic [CNT_W-1:0]         count;
    logic                     accept;

    assign sync = chain[C_SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {C_SYNC_STAGES{C_RESET_BIT}};
        end else begin
            chain <= {chain[C_SYNC_STAGES-2:0], pad};
        end
    end

    // A new level is taken only after the mismatch has persisted through the terminal count.
    assign accept    = (sync != stable) && (count == CNT_LAST);
    assign rise_next = accept & sync;
    assign fall_next = accept & ~sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            stable <= C_RESET_BIT;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= rise_next;
            fall <= fall_next;
            if (sync == stable) begin
                count <= '0;
            end else if (accept) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/user_gpio_in_cond.sv
// GPIO input conditioning: per-bit debounce, sticky edge status with W1C, masked interrupt.
module user_gpio_in_cond
    import user_gpio_pkg::*;
#(
    parameter int          C_WIDTH           = GPIO_WIDTH_DEF,
    parameter int          C_SYNC_STAGES     = GPIO_SYNC_DEF,
    parameter int          C_DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
    parameter logic [31:0] C_RESET_LEVEL     = GPIO_RESET_LVL_DEF
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic [C_WIDTH-1:0] GPIO_PAD_I,
    output logic [C_WIDTH-1:0] USER_GPIO_I,
    output logic [C_WIDTH-1:0] EDGE_RISE_O,
    output logic [C_WIDTH-1:0] EDGE_FALL_O,
    output logic [C_WIDTH-1:0] STICKY_O,
    input  logic [C_WIDTH-1:0] STICKY_CLR_I,
    input  logic [C_WIDTH-1:0] IRQ_MASK_I,
    output logic               IRQ_O
);

    logic [C_WIDTH-1:0] rise_next;
    logic [C_WIDTH-1:0] fall_next;

    for (genvar i = 0; i < C_WIDTH; i++) begin : g_bit
        user_gpio_in_cond_bit #(
            .C_SYNC_STAGES     (C_SYNC_STAGES),
            .C_DEBOUNCE_CYCLES (C_DEBOUNCE_CYCLES),
            .C_RESET_BIT       (C_RESET_LEVEL[i])
        ) u_bit (
            .clk       (S_AXI_ACLK),
            .rst       (S_AXI_ARESET),
            .pad       (GPIO_PAD_I[i]),
            .stable    (USER_GPIO_I[i]),
            .rise      (EDGE_RISE_O[i]),
            .fall      (EDGE_FALL_O[i]),
            .rise_next (rise_next[i]),
            .fall_next (fall_next[i])
        );
    end

    // New edges are OR-ed in after the clear so a coincident set wins.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            STICKY_O <= '0;
            IRQ_O    <= 1'b0;
        end else begin
            STICKY_O <= (STICKY_O & ~STICKY_CLR_I) | rise_next | fall_next;
            IRQ_O    <= |(STICKY_O & IRQ_MASK_I);
        end
    end

endmodule

// File: tb/tb_user_gpio_in_cond.sv
// Directed bench for user_gpio_in_cond with 2 sync stages and a 4-cycle debounce.
module tb_user_gpio_in_cond;

    localparam int          W   = 32;
    localparam logic [31:0] RST = 32'h0000_00F0;

    logic         clk;
    logic         rst;
    logic [W-1:0] pad;
    logic [W-1:0] user_gpio;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] sticky;
    logic [W-1:0] sticky_clr;
    logic [W-1:0] irq_mask;
    logic         irq;

    int compared;
    int mismatched;
    logic [W-1:0] edge_seen;

    user_gpio_in_cond #(
        .C_WIDTH           (W),
        .C_SYNC_STAGES     (2),
        .C_DEBOUNCE_CYCLES (4),
        .C_RESET_LEVEL     (RST)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .GPIO_PAD_I   (pad),
        .USER_GPIO_I  (user_gpio),
        .EDGE_RISE_O  (rise),
        .EDGE_FALL_O  (fall),
        .STICKY_O     (sticky),
        .STICKY_CLR_I (sticky_clr),
        .IRQ_MASK_I   (irq_mask),
        .IRQ_O        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        pad        = RST;
        sticky_clr = '0;
        irq_mask   = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // 1: reset state
        check("reset_user",   user_gpio, 32'h0000_00F0);
        check("reset_rise",   rise,      '0);
        check("reset_fall",   fall,      '0);
        check("reset_sticky", sticky,    '0);
        check("reset_irq",    {31'd0, irq}, '0);

        // 2: clean rise on bit 0, accepted on the 6th edge
        pad[0] = 1'b1;
        tick(5);
        check("rise0_early_user", user_gpio, 32'h0000_00F0);
        check("rise0_early_rise", rise,      '0);
        tick(1);
        check("rise0_user",   user_gpio, 32'h0000_00F1);
        check("rise0_pulse",  rise,      32'h0000_0001);
        check("rise0_sticky", sticky,    32'h0000_0001);
        tick(1);
        check("rise0_pulse_end", rise, '0);

        // 3: three-cycle glitch on bit 3 is rejected
        edge_seen = '0;
        pad[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            edge_seen = edge_seen | rise | fall;
        end
        pad[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            edge_seen = edge_seen | rise | fall;
        end
        check("glitch_user",  user_gpio, 32'h0000_00F1);
        check("glitch_edges", edge_seen, '0);

        // 4: fall on bit 5 with mask, then W1C
        sticky_clr = 32'h0000_0001;
        tick(1);
        sticky_clr = '0;
        check("clr0_sticky", sticky, '0);
        irq_mask = 32'h0000_0020;
        pad[5]   = 1'b0;
        tick(6);
        check("fall5_pulse",  fall,      32'h0000_0020);
        check("fall5_user",   user_gpio, 32'h0000_00D1);
        check("fall5_sticky", sticky,    32'h0000_0020);
        check("fall5_irq_lo", {31'd0, irq}, '0);
        tick(1);
        check("fall5_irq_hi",     {31'd0, irq}, 32'd1);
        check("fall5_pulse_end",  fall, '0);
        sticky_clr = 32'h0000_0020;
        tick(1);
        sticky_clr = '0;
        check("clr5_sticky", sticky, '0);
        tick(1);
        check("clr5_irq", {31'd0, irq}, '0);

        // 5: clear coincident with rise on bit 2, set wins; then unmask
        pad[2] = 1'b1;
        tick(5);
        sticky_clr = 32'h0000_0004;
        tick(1);
        sticky_clr = '0;
        check("setclr2_rise",   rise,   32'h0000_0004);
        check("setclr2_sticky", sticky, 32'h0000_0004);
        tick(1);
        check("setclr2_hold", sticky, 32'h0000_0004);
        check("masked_irq",   {31'd0, irq}, '0);
        irq_mask = 32'h0000_0004;
        tick(1);
        check("unmask_irq", {31'd0, irq}, 32'd1);

        // 6: reset two counts into a rise on bit 8, then multi-bit re-qualification
        pad[8] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("midrst_user",   user_gpio, 32'h0000_00F0);
        check("midrst_sticky", sticky,    '0);
        check("midrst_irq",    {31'd0, irq}, '0);
        tick(5);
        check("requal_early_user", user_gpio, 32'h0000_00F0);
        tick(1);
        check("requal_user", user_gpio, 32'h0000_01D5);
        check("requal_rise", rise,      32'h0000_0105);
        check("requal_fall", fall,      32'h0000_0020);
        check("requal_irq0", {31'd0, irq}, '0);
        tick(1);
        check("requal_sticky", sticky, 32'h0000_0125);
        check("requal_irq1",   {31'd0, irq}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
